pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the width of all address ports and registers.
REQ-002 SHALL have parameter IRQ_VECTOR, default 32'h0000_0010, the interrupt redirect address.
REQ-003 clock  input  1  single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instr_valid  input  1  instruction memory has the word at pc ready.
REQ-006 is_jump, is_branch, is_mem, is_halt, is_iret  input  1 each  decode flags, valid in DECODE.
REQ-007 target_address  input  ADDR_WIDTH  jump/branch target, valid in DECODE.
REQ-008 branch_taken  input  1  ALU condition, valid in EXECUTE.
REQ-009 mem_busy  input  1  data memory is still completing an access.
REQ-010 interrupt_req  input  1  level interrupt request.
REQ-011 resume  input  1  leave HALTED.
REQ-012 pc_current  input  ADDR_WIDTH  current program counter value.
REQ-013 pc_halt  output  1  freezes the program counter when 1.
REQ-014 pc_selector  output  1  0 = pc+1, 1 = jump_address.
REQ-015 jump_address  output  ADDR_WIDTH  redirect address for the program counter.
REQ-016 ir_load, reg_write  output  1 each  instruction-register load strobe and register-file write strobe.
REQ-017 state  output  3  current FSM state encoding.
REQ-018 halted, in_isr  output  1 each  status flags.
REQ-019 epc  output  ADDR_WIDTH  saved return address.
REQ-020 retired_count  output  32  count of retired instructions.

Function
REQ-021 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEMWAIT=3, WRITEBACK=4, HALTED=5; codes 6-7 SHALL return to FETCH on the next edge.
REQ-022 FETCH: hold while instr_valid=0; when instr_valid=1, assert ir_load for that cycle and go to DECODE.
REQ-023 DECODE: latch all decode flags and target_address; go to HALTED if is_halt, else EXECUTE.
REQ-024 EXECUTE: compute the latched redirect flag = jump | (branch & branch_taken) | iret; go to MEMWAIT if is_mem, else WRITEBACK.
REQ-025 MEMWAIT: hold while mem_busy=1, go to WRITEBACK on the first cycle mem_busy=0; a MEMWAIT visit SHALL last at least 1 cycle.
REQ-026 WRITEBACK: assert reg_write=1 and pc_halt=0 for exactly this one cycle; increment retired_count; go to FETCH.
REQ-027 pc_halt SHALL be 1 in every state except WRITEBACK, so the PC advances exactly once per instruction.
REQ-028 In WRITEBACK, pc_selector and jump_address SHALL follow this priority.
REQ-029 Priority 1, taken interrupt (interrupt_req=1 and in_isr=0): pc_selector=1, jump_address=IRQ_VECTOR; epc <= normal next address; in_isr <= 1.
REQ-030 Priority 2, iret: pc_selector=1, jump_address=epc; in_isr <= 0.
REQ-031 Priority 3, jump or taken branch: pc_selector=1, jump_address=latched target.
REQ-032 Otherwise: pc_selector=0 and jump_address holds its previous value.
REQ-033 The normal next address SHALL be the latched target if the redirect flag is set, else pc_current+1, truncated to ADDR_WIDTH.
REQ-034 Interrupts SHALL be sampled only in WRITEBACK; interrupt_req in other states is ignored until WRITEBACK; interrupt_req while in_isr=1 is ignored.
REQ-035 HALTED: halted=1 and pc_halt=1; go to FETCH on the cycle after resume=1; interrupt_req SHALL NOT wake HALTED; the halt instruction SHALL NOT increment retired_count.
REQ-036 retired_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-037 ir_load and reg_write SHALL never be asserted in the same cycle.
REQ-038 state, flags, epc, jump_address and retired_count SHALL be registers.
REQ-039 pc_halt, pc_selector, ir_load and reg_write SHALL be decoded from the current state and registered flags only; no combinational path from any input to these outputs except instr_valid->ir_load and interrupt_req->pc_selector.

Reset
REQ-040 While reset=1, asynchronously set: state=FETCH, pc_halt=1, pc_selector=0, jump_address=0, epc=0, retired_count=0.
REQ-041 While reset=1, asynchronously set: ir_load=0, reg_write=0, halted=0, in_isr=0, all latched flags=0.
REQ-042 Reset asserted in any state, including mid-MEMWAIT or HALTED, SHALL abort the instruction with no reg_write pulse; FETCH resumes on the first edge after deassertion.

Verification
REQ-043 ALU op, instr_valid=1, no flags -> FETCH→DECODE→EXECUTE→WRITEBACK→FETCH in 4 cycles; one pc_halt=0 cycle with pc_selector=0; retired_count=1.
REQ-044 is_branch=1, target=32'h40, branch_taken=1 -> WRITEBACK shows pc_selector=1, jump_address=32'h40; with branch_taken=0, pc_selector=0.
REQ-045 is_mem=1, mem_busy high for 3 cycles -> 3 MEMWAIT cycles, then one WRITEBACK; pc_halt=1 throughout MEMWAIT.
REQ-046 interrupt_req=1 during plain op at pc_current=32'h7 -> jump_address=32'h10, epc=32'h8, in_isr=1; a second interrupt is ignored; iret -> jump_address=32'h8, in_isr=0.
REQ-047 is_halt -> HALTED, halted=1, retired_count unchanged, interrupt_req has no effect; resume=1 -> FETCH next cycle.
REQ-048 retired_count preset near wrap by running 2^32 instructions or by a forced value -> wraps to 0; reset mid-MEMWAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Purpose: bundles the sequencer's decode/control inputs and PC-control/status outputs.
// Latency: none, wires only.
// Backpressure: instr_valid and mem_busy stall the sequencer; nothing stalls the PC side.
interface pc_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  // Instruction / datapath side inputs to the sequencer
  logic                  instr_valid;
  logic                  is_jump;
  logic                  is_branch;
  logic                  is_mem;
  logic                  is_halt;
  logic                  is_iret;
  logic [ADDR_WIDTH-1:0] target_address;
  logic                  branch_taken;
  logic                  mem_busy;
  logic                  interrupt_req;
  logic                  resume;
  logic [ADDR_WIDTH-1:0] pc_current;

  // PC control and status outputs of the sequencer
  logic                  pc_halt;
  logic                  pc_selector;
  logic [ADDR_WIDTH-1:0] jump_address;
  logic                  ir_load;
  logic                  reg_write;
  logic [2:0]            state;
  logic                  halted;
  logic                  in_isr;
  logic [ADDR_WIDTH-1:0] epc;
  logic [31:0]           retired_count;

  // The sequencer itself
  modport master (
    input  instr_valid, is_jump, is_branch, is_mem, is_halt, is_iret,
           target_address, branch_taken, mem_busy, interrupt_req, resume,
           pc_current,
    output pc_halt, pc_selector, jump_address, ir_load, reg_write, state,
           halted, in_isr, epc, retired_count
  );

  // The surrounding core / environment
  modport slave (
    output instr_valid, is_jump, is_branch, is_mem, is_halt, is_iret,
           target_address, branch_taken, mem_busy, interrupt_req, resume,
           pc_current,
    input  pc_halt, pc_selector, jump_address, ir_load, reg_write, state,
           halted, in_isr, epc, retired_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose: multi-cycle instruction sequencer driving PC advance/redirect, with one-level interrupt and halt.
// Latency: 4 cycles per plain instruction (FETCH/DECODE/EXECUTE/WRITEBACK), plus MEMWAIT cycles for memory ops.
// Backpressure: FETCH waits on instr_valid, MEMWAIT waits on mem_busy, HALTED waits on resume.
module pc_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR = 32'h0000_0010
) (
  input  logic          clock,
  input  logic          reset,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMWAIT   = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5
  } state_e;

  state_e                state_q, state_d;

  // Decode flags captured in DECODE; is_halt acts directly on the DECODE transition.
  logic                  jump_q;
  logic                  branch_q;
  logic                  mem_q;
  logic                  iret_q;
  logic [ADDR_WIDTH-1:0] target_q;

  // Redirect decision made in EXECUTE, when branch_taken is valid.
  logic                  redirect_q;
  logic                  redirect_d;

  logic                  in_isr_q;
  logic [ADDR_WIDTH-1:0] epc_q;
  logic [ADDR_WIDTH-1:0] jump_address_q;
  logic [31:0]           retired_q;
  logic [31:0]           retired_d;

  logic                  in_wb;
  logic                  take_irq;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (bus.instr_valid) state_d = DECODE;
      DECODE:    state_d = bus.is_halt ? HALTED : EXECUTE;
      EXECUTE:   state_d = mem_q ? MEMWAIT : WRITEBACK;
      MEMWAIT:   if (!bus.mem_busy) state_d = WRITEBACK;
      WRITEBACK: state_d = FETCH;
      HALTED:    if (bus.resume) state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Redirect/interrupt decode and the normal (non-interrupt) successor address.
  always_comb begin
    in_wb      = (state_q == WRITEBACK);
    redirect_d = jump_q | (branch_q & bus.branch_taken) | iret_q;
    // An interrupt is only taken at an instruction boundary and never nests.
    take_irq   = in_wb & bus.interrupt_req & ~in_isr_q;
    next_addr  = redirect_q ? target_q : (bus.pc_current + ADDR_WIDTH'(1));
    // The counter register reloads every cycle so its value is always owned by this process.
    retired_d  = in_wb ? (retired_q + 32'd1) : retired_q;
  end

  // Decode flag capture, redirect latch, interrupt bookkeeping and redirect target register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jump_q         <= 1'b0;
      branch_q       <= 1'b0;
      mem_q          <= 1'b0;
      iret_q         <= 1'b0;
      target_q       <= '0;
      redirect_q     <= 1'b0;
      in_isr_q       <= 1'b0;
      epc_q          <= '0;
      jump_address_q <= '0;
    end else begin
      case (state_q)
        DECODE: begin
          jump_q   <= bus.is_jump;
          branch_q <= bus.is_branch;
          mem_q    <= bus.is_mem;
          iret_q   <= bus.is_iret;
          target_q <= bus.target_address;
        end
        EXECUTE: begin
          redirect_q <= redirect_d;
          // Stage the lower-priority redirect target ahead of WRITEBACK so the
          // address output comes straight from a register in that cycle.
          if (iret_q)          jump_address_q <= epc_q;
          else if (redirect_d) jump_address_q <= target_q;
        end
        WRITEBACK: begin
          if (take_irq) begin
            epc_q          <= next_addr;
            in_isr_q       <= 1'b1;
            jump_address_q <= IRQ_VECTOR;
          end else if (iret_q) begin
            in_isr_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Retired-instruction counter; wraps naturally at 32 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  // Output decode: only state and registered flags, plus instr_valid into ir_load
  // and interrupt_req into the WRITEBACK redirect select/address.
  always_comb begin
    bus.pc_halt       = ~in_wb;
    bus.reg_write     = in_wb;
    // Reset holds state at FETCH, so gate the strobe explicitly while reset is high.
    bus.ir_load       = (state_q == FETCH) & bus.instr_valid & ~reset;
    bus.pc_selector   = in_wb & (take_irq | redirect_q);
    bus.jump_address  = take_irq ? IRQ_VECTOR : jump_address_q;
    bus.state         = state_q;
    bus.halted        = (state_q == HALTED);
    bus.in_isr        = in_isr_q;
    bus.epc           = epc_q;
    bus.retired_count = retired_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: directed scoreboard bench for pc_sequencer; WRITEBACK results are checked by a monitor.
// Latency: expected records are queued when an instruction is issued and popped on reg_write.
// Backpressure: bench drives instr_valid/mem_busy/resume to exercise every stall.
module tb_pc_sequencer;
  localparam int AW = 32;
  localparam logic [31:0] S_FETCH     = 32'd0;
  localparam logic [31:0] S_DECODE    = 32'd1;
  localparam logic [31:0] S_MEMWAIT   = 32'd3;
  localparam logic [31:0] S_HALTED    = 32'd5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pc_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  pc_sequencer #(.ADDR_WIDTH(AW), .IRQ_VECTOR(32'h0000_0010)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        sel;
    logic [31:0] ja;
    logic [31:0] ret;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_ret  = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: every WRITEBACK cycle is matched against the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      check("ir_load_reg_write_exclusive", 32'(bus.ir_load & bus.reg_write), 32'd0);
      if (bus.reg_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_writeback", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_pc_halt", 32'(bus.pc_halt), 32'd0);
          check("wb_pc_selector", 32'(bus.pc_selector), 32'(e.sel));
          check("wb_jump_address", bus.jump_address, e.ja);
          check("wb_retired_count", bus.retired_count, e.ret);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.instr_valid    = 1'b0;
    bus.is_jump        = 1'b0;
    bus.is_branch      = 1'b0;
    bus.is_mem         = 1'b0;
    bus.is_halt        = 1'b0;
    bus.is_iret        = 1'b0;
    bus.target_address = '0;
    bus.branch_taken   = 1'b0;
    bus.mem_busy       = 1'b0;
    bus.interrupt_req  = 1'b0;
    bus.resume         = 1'b0;
    bus.pc_current     = '0;
  endtask

  // Issue one instruction and follow it back to FETCH (or into HALTED).
  // mem_busy is held high through EXECUTE and the first busy-1 MEMWAIT cycles,
  // so a memory op spends max(busy,1) cycles in MEMWAIT.
  task automatic run_instr(input string nm, input logic j, input logic b, input logic m,
                           input logic h, input logic ir, input logic [31:0] tgt,
                           input logic tk, input int busy, input logic [31:0] pc,
                           input logic irq, input logic exp_sel, input logic [31:0] exp_ja,
                           input int exp_cycles);
    int cyc;
    int mw;
    if (!h) begin
      exp_q.push_back('{exp_sel, exp_ja, exp_ret});
      exp_ret = exp_ret + 32'd1;
    end
    @(posedge clock); #1;
    check({nm, "_start_fetch"}, 32'(bus.state), S_FETCH);
    bus.is_jump        = j;
    bus.is_branch      = b;
    bus.is_mem         = m;
    bus.is_halt        = h;
    bus.is_iret        = ir;
    bus.target_address = tgt;
    bus.branch_taken   = tk;
    bus.pc_current     = pc;
    bus.interrupt_req  = irq;
    bus.mem_busy       = (busy > 0);
    bus.instr_valid    = 1'b1;
    #1;
    check({nm, "_ir_load"}, 32'(bus.ir_load), 32'd1);
    cyc = 0;
    mw  = 0;
    do begin
      @(posedge clock); #1;
      cyc++;
      bus.instr_valid = 1'b0;
      if (32'(bus.state) == S_MEMWAIT) begin
        mw++;
        bus.mem_busy = (mw < busy);
        check({nm, "_memwait_pc_halt"}, 32'(bus.pc_halt), 32'd1);
      end
    end while (32'(bus.state) != S_FETCH && 32'(bus.state) != S_HALTED && cyc < 40);
    check({nm, "_cycles"}, cyc, exp_cycles);
    if (m) check({nm, "_memwait_cycles"}, mw, (busy > 0) ? busy : 1);
    clear_inputs();
  endtask

  initial begin
    int cyc;
    clear_inputs();
    reset = 1'b1;
    bus.instr_valid   = 1'b1;   // must not leak to ir_load while in reset
    bus.interrupt_req = 1'b1;
    #12;
    check("rst_state", 32'(bus.state), S_FETCH);
    check("rst_pc_halt", 32'(bus.pc_halt), 32'd1);
    check("rst_pc_selector", 32'(bus.pc_selector), 32'd0);
    check("rst_jump_address", bus.jump_address, 32'd0);
    check("rst_epc", bus.epc, 32'd0);
    check("rst_retired", bus.retired_count, 32'd0);
    check("rst_ir_load", 32'(bus.ir_load), 32'd0);
    check("rst_reg_write", 32'(bus.reg_write), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_in_isr", 32'(bus.in_isr), 32'd0);
    clear_inputs();
    @(posedge clock); #1;
    reset = 1'b0;

    //        name       j b m h i  target      tk busy pc          irq sel ja           cycles
    run_instr("alu",     0,0,0,0,0, 32'h0,      0, 0,   32'h0,      0,  0,  32'h0,       4);
    check("alu_retired", bus.retired_count, 32'd1);
    run_instr("br_tk",   0,1,0,0,0, 32'h40,     1, 0,   32'h1,      0,  1,  32'h40,      4);
    run_instr("br_nt",   0,1,0,0,0, 32'h80,     0, 0,   32'h2,      0,  0,  32'h40,      4);
    run_instr("jump",    1,0,0,0,0, 32'h123,    0, 0,   32'h3,      0,  1,  32'h123,     4);
    run_instr("mem3",    0,0,1,0,0, 32'h0,      0, 3,   32'h4,      0,  0,  32'h123,     7);
    run_instr("irq",     0,0,0,0,0, 32'h0,      0, 0,   32'h7,      1,  1,  32'h10,      4);
    check("irq_epc", bus.epc, 32'h8);
    check("irq_in_isr", 32'(bus.in_isr), 32'd1);
    run_instr("irq2",    0,0,0,0,0, 32'h0,      0, 0,   32'h10,     1,  0,  32'h10,      4);
    check("irq2_epc", bus.epc, 32'h8);
    check("irq2_in_isr", 32'(bus.in_isr), 32'd1);
    run_instr("iret",    0,0,0,0,1, 32'h55,     0, 0,   32'h11,     0,  1,  32'h8,       4);
    check("iret_in_isr", 32'(bus.in_isr), 32'd0);

    // Halt: no retirement, interrupts cannot wake it, resume returns to FETCH.
    run_instr("halt",    0,0,0,1,0, 32'h0,      0, 0,   32'h8,      0,  0,  32'h0,       2);
    check("halt_halted", 32'(bus.halted), 32'd1);
    check("halt_pc_halt", 32'(bus.pc_halt), 32'd1);
    check("halt_retired", bus.retired_count, 32'd8);
    bus.interrupt_req = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("halt_irq_state", 32'(bus.state), S_HALTED);
    check("halt_irq_in_isr", 32'(bus.in_isr), 32'd0);
    bus.interrupt_req = 1'b0;
    bus.resume = 1'b1;
    @(posedge clock); #1;
    bus.resume = 1'b0;
    check("resume_state", 32'(bus.state), S_FETCH);
    check("resume_halted", 32'(bus.halted), 32'd0);

    // Counter wrap from a preset value.
    force dut.retired_q = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    release dut.retired_q;
    @(posedge clock); #1;
    check("wrap_preset", bus.retired_count, 32'hFFFF_FFFF);
    exp_ret = 32'hFFFF_FFFF;
    run_instr("wrap",    0,0,0,0,0, 32'h0,      0, 0,   32'h9,      0,  0,  32'h8,       4);
    check("wrap_zero", bus.retired_count, 32'd0);

    // Reset in the middle of a long MEMWAIT: immediate reset values, no writeback.
    check("pre_reset_drained", exp_q.size(), 32'd0);
    @(posedge clock); #1;
    bus.is_mem      = 1'b1;
    bus.mem_busy    = 1'b1;
    bus.instr_valid = 1'b1;
    cyc = 0;
    do begin
      @(posedge clock); #1;
      cyc++;
      bus.instr_valid = 1'b0;
    end while (32'(bus.state) != S_MEMWAIT && cyc < 20);
    check("mw_reached", 32'(bus.state), S_MEMWAIT);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("mwrst_state", 32'(bus.state), S_FETCH);
    check("mwrst_pc_halt", 32'(bus.pc_halt), 32'd1);
    check("mwrst_reg_write", 32'(bus.reg_write), 32'd0);
    check("mwrst_jump_address", bus.jump_address, 32'd0);
    check("mwrst_epc", bus.epc, 32'd0);
    check("mwrst_retired", bus.retired_count, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    clear_inputs();
    reset = 1'b0;
    exp_ret = 32'd0;
    run_instr("post_rst", 0,0,0,0,0, 32'h0,     0, 0,   32'h20,     0,  0,  32'h0,       4);
    check("post_rst_retired", bus.retired_count, 32'd1);

    repeat (2) @(posedge clock);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
